softmax_stream: RTL and testbench

- Parametrised successor of the single-beat 32-lane softmax.
- Computes an int8 softmax over a row of up to LANES*MAX_BEATS int8 scores, streamed as LANES-wide beats, with a runtime row length and per-lane masking.
- Buffers the row internally and runs max, exp/sum, reciprocal and normalise passes.
- Sits between the QK^T score path and the attention-weight x V matmul in the BERT encoder.

---
 rtl/softmax_stream_if.sv | 26 ++
 rtl/softmax_stream.sv | 130 +++++++++++++
 tb/tb_softmax_stream.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_stream_if.sv
// softmax_stream_if: score-beat input, probability-beat output and per-row config for softmax_stream.
interface softmax_stream_if #(
    parameter int LANES  = 32,
    parameter int BEAT_W = 3
);
    logic               data_in_valid;
    logic               data_in_ready;
    logic [LANES*8-1:0] in_data;
    logic [LANES-1:0]   in_mask;
    logic [BEAT_W-1:0]  row_beats;
    logic [15:0]        in_scale;
    logic [4:0]         S;
    logic [15:0]        out_scale;
    logic               data_out_valid;
    logic               data_out_ready;
    logic [LANES*8-1:0] out_data;
    logic               busy;
    modport master (
        output data_in_valid, in_data, in_mask, row_beats, in_scale, S, out_scale, data_out_ready,
        input  data_in_ready, data_out_valid, out_data, busy
    );
    modport slave (
        input  data_in_valid, in_data, in_mask, row_beats, in_scale, S, out_scale, data_out_ready,
        output data_in_ready, data_out_valid, out_data, busy
    );
endinterface

// File: rtl/softmax_stream.sv
// softmax_stream: row-buffered int8 softmax over up to LANES*MAX_BEATS scores streamed as LANES-wide beats.
// Passes: load+max, base-2 exp/sum, restoring reciprocal of the sum, normalise-and-emit.
module softmax_stream #(
    parameter int LANES     = 32,
    parameter int MAX_BEATS = 4,
    parameter int BEAT_W    = 3
) (
    input  logic            clk,
    input  logic            rst,
    softmax_stream_if.slave io
);
    localparam int AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int SW = 16 + $clog2(LANES * MAX_BEATS);

    typedef enum logic [2:0] {IDLE, LOAD, EXP, DIV, OUT} state_t;

    state_t            state_q, state_d;
    logic [15:0]       row_q [MAX_BEATS][LANES];
    logic [LANES-1:0]  msk_q [MAX_BEATS];
    logic signed [7:0] rd_q [LANES];
    logic [LANES-1:0]  rdm_q;
    logic [BEAT_W-1:0] nb_q, k_q, nb_in;
    logic [15:0]       isc_q, osc_q;
    logic [4:0]        s_q, dc_q;
    logic signed [7:0] m_q, mx;
    logic [SW-1:0]     sum_q, rem_q, esum;
    logic [31:0]       quot_q, recip;
    logic [SW:0]       part;
    logic [15:0]       e_v [LANES];
    logic              acc, last_in, ge;
    logic [AW-1:0]     ki, wi, li;

    // Q4 base-2 exponent t: integer part shifts, fraction linearly interpolates the mantissa.
    function automatic logic [15:0] exp_q4(input logic [8:0] d, input logic [15:0] isc, input logic [4:0] s);
        logic [24:0] t;
        t = (25'(d) * 25'(isc)) >> (s - 5'd4);
        return (t[24:8] != '0) ? 16'd0 : (16'h8000 - {2'b00, t[3:0], 10'd0}) >> t[7:4];
    endfunction

    function automatic logic [7:0] norm(input logic [15:0] e, input logic [15:0] os, input logic [31:0] rc);
        logic [63:0] y;
        y = (64'(e) * 64'(os) * 64'(rc) + 64'h4000_0000) >> 31;
        return (y > 64'd127) ? 8'd127 : y[7:0];
    endfunction

    always_comb begin
        nb_in   = (io.row_beats == '0) ? BEAT_W'(1) :
                  (io.row_beats > BEAT_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS) : io.row_beats;
        ki      = k_q[AW-1:0];
        wi      = ki - 1'b1;
        li      = (state_q == IDLE) ? '0 : ki;
        acc     = io.data_in_valid && io.data_in_ready;
        last_in = (state_q == IDLE) ? (nb_in == BEAT_W'(1)) : (k_q + 1'b1 == nb_q);
        mx      = (state_q == IDLE) ? 8'sh80 : m_q;
        for (int i = 0; i < LANES; i++)
            if (!io.in_mask[i] && $signed(io.in_data[8*i+:8]) > mx) mx = $signed(io.in_data[8*i+:8]);
        esum = '0;
        for (int i = 0; i < LANES; i++) begin
            e_v[i] = rdm_q[i] ? 16'd0 : exp_q4({m_q[7], m_q} - {rd_q[i][7], rd_q[i]}, isc_q, s_q);
            esum   = esum + SW'(e_v[i]);
        end
        part  = {rem_q, dc_q == 5'd0};
        ge    = part >= {1'b0, sum_q};
        recip = (sum_q == '0) ? '0 : quot_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = last_in ? EXP : LOAD;
            LOAD:    if (acc && last_in) state_d = EXP;
            EXP:     if (k_q == nb_q) state_d = DIV;
            DIV:     if (dc_q == 5'd31) state_d = OUT;
            OUT:     if (io.data_out_ready && k_q == nb_q - 1'b1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io.data_in_ready  = rst && (state_q == IDLE || state_q == LOAD);
        io.data_out_valid = rst && state_q == OUT;
        io.busy           = rst && state_q != IDLE;
        io.out_data       = '0;
        if (state_q == OUT)
            for (int i = 0; i < LANES; i++) io.out_data[8*i+:8] = norm(row_q[ki][i], osc_q, recip);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                for (int i = 0; i < LANES; i++) row_q[li][i] <= {8'd0, io.in_data[8*i+:8]};
                msk_q[li] <= io.in_mask;
                m_q       <= mx;
                sum_q     <= '0;
                k_q       <= last_in ? '0 : (state_q == IDLE) ? BEAT_W'(1) : k_q + 1'b1;
                if (state_q == IDLE) begin
                    nb_q  <= nb_in;
                    isc_q <= io.in_scale;
                    s_q   <= io.S;
                    osc_q <= io.out_scale;
                end
            end
            // EXP is a two-stage pipe: read beat k, write e of beat k-1 back in place.
            if (state_q == EXP) begin
                if (k_q != nb_q) begin
                    for (int i = 0; i < LANES; i++) rd_q[i] <= $signed(row_q[ki][i][7:0]);
                    rdm_q <= msk_q[ki];
                end
                if (k_q != '0) begin
                    for (int i = 0; i < LANES; i++) row_q[wi][i] <= e_v[i];
                    sum_q <= sum_q + esum;
                end
                k_q    <= (k_q == nb_q) ? '0 : k_q + 1'b1;
                rem_q  <= '0;
                quot_q <= '0;
                dc_q   <= '0;
            end
            if (state_q == DIV) begin
                rem_q  <= ge ? SW'(part - {1'b0, sum_q}) : part[SW-1:0];
                quot_q <= {quot_q[30:0], ge};
                dc_q   <= dc_q + 1'b1;
            end
            if (state_q == OUT && io.data_out_ready) k_q <= k_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: directed rows checked beat-by-beat against a behavioural softmax model,
// plus hand-computed lane values, latency, backpressure and reset checks.
module tb_softmax_stream;
    localparam int LANES = 32, MAX_BEATS = 4, BEAT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    softmax_stream_if #(.LANES(LANES), .BEAT_W(BEAT_W)) io ();
    softmax_stream #(.LANES(LANES), .MAX_BEATS(MAX_BEATS), .BEAT_W(BEAT_W)) dut (.clk(clk), .rst(rst), .io(io));

    int n_chk = 0, n_fail = 0, beats_seen = 0;
    logic signed [7:0]  rx [MAX_BEATS][LANES];
    logic               rm [MAX_BEATS][LANES];
    logic [LANES*8-1:0] exp_q [$];
    logic [LANES*8-1:0] last_beat, exp_beat, hold_d;
    bit                 stall_q = 1'b0;
    int                 bad_l;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int lane(input logic [LANES*8-1:0] b, input int l);
        return int'($signed(b[8*l+:8]));
    endfunction

    // Reference: softmax rules applied with plain integer arithmetic over the whole row.
    task automatic model(input int nb, input int isc, input int s, input int osc);
        int m;
        longint e [MAX_BEATS][LANES];
        longint sum, rc, y, t;
        logic [LANES*8-1:0] beat;
        m = -128;
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < LANES; l++)
                if (!rm[b][l] && int'(rx[b][l]) > m) m = int'(rx[b][l]);
        sum = 0;
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < LANES; l++) begin
                t = (longint'(m - int'(rx[b][l])) * isc) >> (s - 4);
                e[b][l] = rm[b][l] ? 0 : ((t / 16) >= 16) ? 0 : (32768 - (t % 16) * 1024) >> (t / 16);
                sum += e[b][l];
            end
        rc = (sum == 0) ? 0 : (longint'(1) << 31) / sum;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LANES; l++) begin
                y = (e[b][l] * osc * rc + (longint'(1) << 30)) >> 31;
                beat[8*l+:8] = (y > 127) ? 8'd127 : 8'(y);
            end
            exp_q.push_back(beat);
        end
    endtask

    task automatic fill(input int v);
        for (int b = 0; b < MAX_BEATS; b++)
            for (int l = 0; l < LANES; l++) begin
                rx[b][l] = 8'(v);
                rm[b][l] = 1'b0;
            end
    endtask

    // Later beats carry junk config, which the DUT must ignore.
    task automatic run_row(input int rb, input int isc, input int s, input int osc, input bit push);
        int nb, w;
        nb = (rb == 0) ? 1 : (rb > MAX_BEATS) ? MAX_BEATS : rb;
        if (push) model(nb, isc, s, osc);
        for (int b = 0; b < nb; b++) begin
            io.data_in_valid = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                io.in_data[8*l+:8] = rx[b][l];
                io.in_mask[l]      = rm[b][l];
            end
            io.row_beats = (b == 0) ? BEAT_W'(rb) : BEAT_W'(1);
            io.in_scale  = (b == 0) ? 16'(isc) : 16'd0;
            io.S         = (b == 0) ? 5'(s) : 5'd4;
            io.out_scale = (b == 0) ? 16'(osc) : 16'd0;
            w = 0;
            while (!io.data_in_ready && w < 100) begin
                @(posedge clk); #2;
                w++;
            end
            if (w >= 100) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #2;
        end
        io.data_in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!io.data_out_valid && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0, bad = 0;
        while (io.busy && n < 400) begin
            if (io.data_in_ready) bad++;
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_done"}, io.busy, 0);
        chk({tag, "_ready_low"}, bad, 0);
        chk({tag, "_ready_back"}, io.data_in_ready, 1);
        chk({tag, "_valid_off"}, io.data_out_valid, 0);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && stall_q) begin
            chk("stall_valid", io.data_out_valid, 1);
            chk("stall_data", io.out_data == hold_d, 1);
        end
        stall_q = rst && io.data_out_valid && !io.data_out_ready;
        hold_d  = io.out_data;
        if (rst && io.data_out_valid && io.data_out_ready) begin
            beats_seen++;
            last_beat = io.out_data;
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                exp_beat = exp_q.pop_front();
                bad_l = 0;
                for (int l = LANES - 1; l >= 0; l--)
                    if (io.out_data[8*l+:8] != exp_beat[8*l+:8]) bad_l = l;
                chk($sformatf("beat%0d_lane%0d", beats_seen, bad_l), lane(io.out_data, bad_l), lane(exp_beat, bad_l));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, b0;
        io.data_in_valid = 1'b0; io.in_data = '0; io.in_mask = '0; io.row_beats = '0;
        io.in_scale = '0; io.S = 5'd16; io.out_scale = '0; io.data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", io.data_in_ready, 0);
        chk("rst_out_valid", io.data_out_valid, 0);
        chk("rst_busy", io.busy, 0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", io.data_in_ready, 1);
        @(posedge clk); #2;

        // 1: uniform row, one beat
        fill(5);
        b0 = beats_seen;
        run_row(1, 256, 16, 128, 1);
        wait_valid(n);
        chk("t1_latency", n, 34);
        wait_idle("t1");
        chk("t1_beats", beats_seen - b0, 1);
        chk("t1_lane0", lane(last_beat, 0), 4);
        chk("t1_lane31", lane(last_beat, 31), 4);

        // 2: one dominant lane, then saturation
        fill(-128);
        rx[0][0] = 8'sd127;
        run_row(1, 20132, 16, 127, 1);
        wait_idle("t2a");
        chk("t2a_lane0", lane(last_beat, 0), 127);
        chk("t2a_lane1", lane(last_beat, 1), 0);
        run_row(1, 20132, 16, 200, 1);
        wait_idle("t2b");
        chk("t2b_lane0_sat", lane(last_beat, 0), 127);

        // 3: four equal beats
        fill(-7);
        b0 = beats_seen;
        run_row(4, 1000, 12, 128, 1);
        chk("t3_ready_5th", io.data_in_ready, 0);
        wait_valid(n);
        chk("t3_latency", n, 37);
        wait_idle("t3");
        chk("t3_beats", beats_seen - b0, 4);
        chk("t3_lane5", lane(last_beat, 5), 1);

        // 5: backpressure on test 3, with stray input valids while busy
        b0 = beats_seen;
        io.data_out_ready = 1'b0;
        run_row(4, 1000, 12, 128, 1);
        io.data_in_valid = 1'b1; io.row_beats = BEAT_W'(1); io.in_data = '1;
        wait_valid(n);
        io.data_in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #2;
        end
        chk("t5_no_early_beat", beats_seen - b0, 0);
        io.data_out_ready = 1'b1;
        wait_idle("t5");
        chk("t5_beats_once", beats_seen - b0, 4);

        // 4: all lanes masked, then upper half masked
        fill(3);
        for (int b = 0; b < MAX_BEATS; b++)
            for (int l = 0; l < LANES; l++) rm[b][l] = 1'b1;
        b0 = beats_seen;
        run_row(2, 1000, 12, 128, 1);
        wait_idle("t4a");
        chk("t4a_beats", beats_seen - b0, 2);
        chk("t4a_zero", last_beat == '0, 1);
        fill(3);
        for (int l = 16; l < LANES; l++) rm[0][l] = 1'b1;
        run_row(1, 1000, 12, 128, 1);
        wait_idle("t4b");
        chk("t4b_lane0", lane(last_beat, 0), 8);
        chk("t4b_lane20", lane(last_beat, 20), 0);

        // row_beats boundaries with varied scores and masks
        for (int b = 0; b < MAX_BEATS; b++)
            for (int l = 0; l < LANES; l++) begin
                rx[b][l] = 8'((b * 37 + l * 11) % 256 - 128);
                rm[b][l] = ((b + l) % 7) == 0;
            end
        b0 = beats_seen;
        run_row(0, 700, 9, 300, 1);
        wait_idle("rb0");
        chk("rb0_beats", beats_seen - b0, 1);
        b0 = beats_seen;
        run_row(7, 5000, 12, 255, 1);
        wait_idle("rb7");
        chk("rb7_beats", beats_seen - b0, 4);

        // 6: reset in the middle of DIV, then a clean row
        fill(5);
        b0 = beats_seen;
        run_row(1, 256, 16, 128, 0);
        repeat (10) begin
            @(posedge clk); #2;
        end
        chk("t6_in_div", io.busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_in_ready", io.data_in_ready, 0);
        chk("t6_rst_out_valid", io.data_out_valid, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_busy", io.busy, 0);
        chk("t6_out_valid", io.data_out_valid, 0);
        chk("t6_in_ready", io.data_in_ready, 1);
        repeat (40) begin
            @(posedge clk); #2;
        end
        chk("t6_no_output", beats_seen - b0, 0);
        run_row(1, 256, 16, 128, 1);
        wait_valid(n);
        chk("t6_latency", n, 34);
        wait_idle("t6");
        chk("t6_lane0", lane(last_beat, 0), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
